// File: rtl/rf_pkg.sv
// Shared widths, sentinel encodings and helpers for the multi-port register file.
// Index/tag MSB set means "no register" / "no dependency".
package rf_pkg;

    localparam int RF_XLEN      = 32;
    localparam int RF_REG_WIDTH = 5;
    localparam int RF_ROB_WIDTH = 8;
    localparam int RF_DP_WIDTH  = 2;
    localparam int RF_CM_WIDTH  = 2;

    localparam logic [RF_REG_WIDTH:0] NON_REG = {1'b1, {RF_REG_WIDTH{1'b0}}};
    localparam logic [RF_ROB_WIDTH:0] NON_DEP = {1'b1, {RF_ROB_WIDTH{1'b0}}};

    // True only for a real, writable register (not NON_REG and not x0).
    function automatic logic is_reg(input logic [RF_REG_WIDTH:0] idx);
        return !idx[RF_REG_WIDTH] && (idx[RF_REG_WIDTH-1:0] != '0);
    endfunction

    function automatic logic [RF_ROB_WIDTH:0] mk_tag(input logic [RF_ROB_WIDTH-1:0] rob);
        return {1'b0, rob};
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// Resolves one source operand of one dispatch slot: sentinel/x0, flush,
// forwarding from older slots, commit bypass, then stored state.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN      = RF_XLEN,
    parameter int REG_WIDTH = RF_REG_WIDTH,
    parameter int ROB_WIDTH = RF_ROB_WIDTH,
    parameter int DP_WIDTH  = RF_DP_WIDTH,
    parameter int CM_WIDTH  = RF_CM_WIDTH,
    parameter int SLOT      = 0
) (
    input  logic [REG_WIDTH:0]                src,
    input  logic                              flush,
    input  logic [DP_WIDTH-1:0]               dp_en,
    input  logic [DP_WIDTH*(REG_WIDTH+1)-1:0] dp_rd,
    input  logic [DP_WIDTH*ROB_WIDTH-1:0]     dp_rob,
    input  logic [CM_WIDTH-1:0]               cm_en,
    input  logic [CM_WIDTH*ROB_WIDTH-1:0]     cm_rob,
    input  logic [CM_WIDTH*(REG_WIDTH+1)-1:0] cm_rd,
    input  logic [CM_WIDTH*XLEN-1:0]          cm_value,
    input  logic [ROB_WIDTH:0]                dep_tag,
    input  logic [XLEN-1:0]                   reg_value,
    output logic [ROB_WIDTH:0]                q,
    output logic [XLEN-1:0]                   v
);

    localparam int IDX_W = REG_WIDTH + 1;

    logic                 fwd_hit;
    logic [ROB_WIDTH:0]   fwd_tag;
    logic                 byp_hit;
    logic [XLEN-1:0]      byp_value;

    // Later iterations overwrite earlier ones, so the youngest older slot wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_tag = NON_DEP;
        for (int i = 0; i < DP_WIDTH; i++) begin
            if (i < SLOT && dp_en[i] && dp_rd[i*IDX_W +: IDX_W] == src) begin
                fwd_hit = 1'b1;
                fwd_tag = mk_tag(dp_rob[i*ROB_WIDTH +: ROB_WIDTH]);
            end
        end
    end

    always_comb begin
        byp_hit   = 1'b0;
        byp_value = '0;
        for (int k = 0; k < CM_WIDTH; k++) begin
            if (cm_en[k] && cm_rd[k*IDX_W +: IDX_W] == src &&
                dep_tag == mk_tag(cm_rob[k*ROB_WIDTH +: ROB_WIDTH])) begin
                byp_hit   = 1'b1;
                byp_value = cm_value[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        q = NON_DEP;
        v = '0;
        if (!is_reg(src) || flush) begin
            q = NON_DEP;
            v = '0;
        end else if (fwd_hit) begin
            q = fwd_tag;
        end else if (byp_hit) begin
            v = byp_value;
        end else if (dep_tag == NON_DEP) begin
            v = reg_value;
        end else begin
            q = dep_tag;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-issue architectural register file with per-register RoB dependency tags,
// multi-commit writeback and single-cycle mispredict flush.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN      = RF_XLEN,
    parameter int REG_WIDTH = RF_REG_WIDTH,
    parameter int ROB_WIDTH = RF_ROB_WIDTH,
    parameter int DP_WIDTH  = RF_DP_WIDTH,
    parameter int CM_WIDTH  = RF_CM_WIDTH
) (
    input  logic                              Sys_clk,
    input  logic                              Sys_rst,
    input  logic                              Sys_rdy,
    input  logic [DP_WIDTH-1:0]               DPRF_en,
    input  logic [DP_WIDTH*(REG_WIDTH+1)-1:0] DPRF_rs1,
    input  logic [DP_WIDTH*(REG_WIDTH+1)-1:0] DPRF_rs2,
    input  logic [DP_WIDTH*(REG_WIDTH+1)-1:0] DPRF_rd,
    input  logic [DP_WIDTH*ROB_WIDTH-1:0]     DPRF_RoB_index,
    output logic [DP_WIDTH*(ROB_WIDTH+1)-1:0] RFDP_Qj,
    output logic [DP_WIDTH*(ROB_WIDTH+1)-1:0] RFDP_Qk,
    output logic [DP_WIDTH*XLEN-1:0]          RFDP_Vj,
    output logic [DP_WIDTH*XLEN-1:0]          RFDP_Vk,
    input  logic [CM_WIDTH-1:0]               RoBRF_en,
    input  logic [CM_WIDTH*ROB_WIDTH-1:0]     RoBRF_RoB_index,
    input  logic [CM_WIDTH*(REG_WIDTH+1)-1:0] RoBRF_rd,
    input  logic [CM_WIDTH*XLEN-1:0]          RoBRF_value,
    input  logic                              RoBRF_flush
);

    localparam int NUM_REGS = 2 ** REG_WIDTH;
    localparam int IDX_W    = REG_WIDTH + 1;
    localparam int TAG_W    = ROB_WIDTH + 1;

    logic [XLEN-1:0]  reg_q [NUM_REGS];
    logic [XLEN-1:0]  reg_d [NUM_REGS];
    logic [TAG_W-1:0] dep_q [NUM_REGS];
    logic [TAG_W-1:0] dep_d [NUM_REGS];

    // Commits first, then flush or rename, so a same-cycle rename overrides a commit clear.
    always_comb begin
        reg_d = reg_q;
        dep_d = dep_q;
        if (Sys_rdy) begin
            for (int k = 0; k < CM_WIDTH; k++) begin
                if (RoBRF_en[k] && is_reg(RoBRF_rd[k*IDX_W +: IDX_W])) begin
                    reg_d[RoBRF_rd[k*IDX_W +: REG_WIDTH]] = RoBRF_value[k*XLEN +: XLEN];
                    if (dep_q[RoBRF_rd[k*IDX_W +: REG_WIDTH]] ==
                        mk_tag(RoBRF_RoB_index[k*ROB_WIDTH +: ROB_WIDTH])) begin
                        dep_d[RoBRF_rd[k*IDX_W +: REG_WIDTH]] = NON_DEP;
                    end
                end
            end
            if (RoBRF_flush) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    dep_d[i] = NON_DEP;
                end
            end else begin
                for (int j = 0; j < DP_WIDTH; j++) begin
                    if (DPRF_en[j] && is_reg(DPRF_rd[j*IDX_W +: IDX_W])) begin
                        dep_d[DPRF_rd[j*IDX_W +: REG_WIDTH]] =
                            mk_tag(DPRF_RoB_index[j*ROB_WIDTH +: ROB_WIDTH]);
                    end
                end
            end
        end
    end

    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
                dep_q[i] <= NON_DEP;
            end
        end else begin
            reg_q <= reg_d;
            dep_q <= dep_d;
        end
    end

    for (genvar j = 0; j < DP_WIDTH; j++) begin : g_slot
        rf_read_port #(
            .XLEN(XLEN), .REG_WIDTH(REG_WIDTH), .ROB_WIDTH(ROB_WIDTH),
            .DP_WIDTH(DP_WIDTH), .CM_WIDTH(CM_WIDTH), .SLOT(j)
        ) u_rs1 (
            .src       (DPRF_rs1[j*IDX_W +: IDX_W]),
            .flush     (RoBRF_flush),
            .dp_en     (DPRF_en),
            .dp_rd     (DPRF_rd),
            .dp_rob    (DPRF_RoB_index),
            .cm_en     (RoBRF_en),
            .cm_rob    (RoBRF_RoB_index),
            .cm_rd     (RoBRF_rd),
            .cm_value  (RoBRF_value),
            .dep_tag   (dep_q[DPRF_rs1[j*IDX_W +: REG_WIDTH]]),
            .reg_value (reg_q[DPRF_rs1[j*IDX_W +: REG_WIDTH]]),
            .q         (RFDP_Qj[j*TAG_W +: TAG_W]),
            .v         (RFDP_Vj[j*XLEN +: XLEN])
        );

        rf_read_port #(
            .XLEN(XLEN), .REG_WIDTH(REG_WIDTH), .ROB_WIDTH(ROB_WIDTH),
            .DP_WIDTH(DP_WIDTH), .CM_WIDTH(CM_WIDTH), .SLOT(j)
        ) u_rs2 (
            .src       (DPRF_rs2[j*IDX_W +: IDX_W]),
            .flush     (RoBRF_flush),
            .dp_en     (DPRF_en),
            .dp_rd     (DPRF_rd),
            .dp_rob    (DPRF_RoB_index),
            .cm_en     (RoBRF_en),
            .cm_rob    (RoBRF_RoB_index),
            .cm_rd     (RoBRF_rd),
            .cm_value  (RoBRF_value),
            .dep_tag   (dep_q[DPRF_rs2[j*IDX_W +: REG_WIDTH]]),
            .reg_value (reg_q[DPRF_rs2[j*IDX_W +: REG_WIDTH]]),
            .q         (RFDP_Qk[j*TAG_W +: TAG_W]),
            .v         (RFDP_Vk[j*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed, table-driven bench for register_file_mp: each record drives one cycle
// of inputs and lists the hand-computed combinational read results for that cycle.
module tb_register_file_mp;

    localparam logic [8:0] ND = 9'h100;
    localparam logic [5:0] NR = 6'h20;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst;
    logic        Sys_rdy;
    logic [1:0]  DPRF_en;
    logic [11:0] DPRF_rs1, DPRF_rs2, DPRF_rd;
    logic [15:0] DPRF_RoB_index;
    logic [17:0] RFDP_Qj, RFDP_Qk;
    logic [63:0] RFDP_Vj, RFDP_Vk;
    logic [1:0]  RoBRF_en;
    logic [15:0] RoBRF_RoB_index;
    logic [11:0] RoBRF_rd;
    logic [63:0] RoBRF_value;
    logic        RoBRF_flush;

    int num_checks = 0;
    int num_fails  = 0;

    typedef struct {
        logic        rdy;
        logic        flush;
        logic [1:0]  dp_en;
        logic [11:0] rs1, rs2, rd;
        logic [15:0] rob;
        logic [1:0]  cm_en;
        logic [15:0] cm_rob;
        logic [11:0] cm_rd;
        logic [63:0] cm_val;
        logic [17:0] qj, qk;
        logic [63:0] vj, vk;
    } vec_t;

    vec_t vecs[$];

    register_file_mp dut (
        .Sys_clk         (Sys_clk),
        .Sys_rst         (Sys_rst),
        .Sys_rdy         (Sys_rdy),
        .DPRF_en         (DPRF_en),
        .DPRF_rs1        (DPRF_rs1),
        .DPRF_rs2        (DPRF_rs2),
        .DPRF_rd         (DPRF_rd),
        .DPRF_RoB_index  (DPRF_RoB_index),
        .RFDP_Qj         (RFDP_Qj),
        .RFDP_Qk         (RFDP_Qk),
        .RFDP_Vj         (RFDP_Vj),
        .RFDP_Vk         (RFDP_Vk),
        .RoBRF_en        (RoBRF_en),
        .RoBRF_RoB_index (RoBRF_RoB_index),
        .RoBRF_rd        (RoBRF_rd),
        .RoBRF_value     (RoBRF_value),
        .RoBRF_flush     (RoBRF_flush)
    );

    always #5 Sys_clk = ~Sys_clk;

    function automatic logic [5:0] r(input int n);
        return 6'(n);
    endfunction

    function automatic logic [8:0] t(input int n);
        return 9'(n);
    endfunction

    task automatic addVec(input logic rdy, input logic flush, input logic [1:0] dp_en,
                          input logic [11:0] rs1, input logic [11:0] rs2,
                          input logic [11:0] rd, input logic [15:0] rob,
                          input logic [1:0] cm_en, input logic [15:0] cm_rob,
                          input logic [11:0] cm_rd, input logic [63:0] cm_val,
                          input logic [17:0] qj, input logic [63:0] vj,
                          input logic [17:0] qk, input logic [63:0] vk);
        vec_t v;
        v.rdy = rdy; v.flush = flush; v.dp_en = dp_en;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rob = rob;
        v.cm_en = cm_en; v.cm_rob = cm_rob; v.cm_rd = cm_rd; v.cm_val = cm_val;
        v.qj = qj; v.vj = vj; v.qk = qk; v.vk = vk;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        Sys_rdy         = v.rdy;
        RoBRF_flush     = v.flush;
        DPRF_en         = v.dp_en;
        DPRF_rs1        = v.rs1;
        DPRF_rs2        = v.rs2;
        DPRF_rd         = v.rd;
        DPRF_RoB_index  = v.rob;
        RoBRF_en        = v.cm_en;
        RoBRF_RoB_index = v.cm_rob;
        RoBRF_rd        = v.cm_rd;
        RoBRF_value     = v.cm_val;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, "_qj"}, 64'(RFDP_Qj), 64'(v.qj));
        checkOutput({tag, "_vj"}, RFDP_Vj, v.vj);
        checkOutput({tag, "_qk"}, 64'(RFDP_Qk), 64'(v.qk));
        checkOutput({tag, "_vk"}, RFDP_Vk, v.vk);
    endtask

    initial begin
        // v0: idle reads right after reset
        addVec(1, 0, 2'b00, {r(31), r(1)}, {r(3), r(2)}, {NR, NR}, 16'h0,
               2'b00, 16'h0, {NR, NR}, 64'h0, {ND, ND}, 64'h0, {ND, ND}, 64'h0);
        // v1: slot0 renames x5->3, slot1 reads x5 through intra-group forwarding
        addVec(1, 0, 2'b11, {r(5), r(1)}, {r(6), r(2)}, {r(7), r(5)}, {8'd4, 8'd3},
               2'b00, 16'h0, {NR, NR}, 64'h0, {t(3), ND}, 64'h0, {ND, ND}, 64'h0);
        // v2: stored deps visible; x0 and NON_REG sources read as zero
        addVec(1, 0, 2'b00, {r(0), r(5)}, {NR, r(7)}, {NR, NR}, 16'h0,
               2'b00, 16'h0, {NR, NR}, 64'h0, {ND, t(3)}, 64'h0, {ND, t(4)}, 64'h0);
        // v3: commit slot1 RoB3 x5=DEAD bypassed; slot1 x9 forwarded from slot0
        addVec(1, 0, 2'b01, {r(9), r(5)}, {r(5), r(7)}, {NR, r(9)}, {8'd0, 8'd10},
               2'b10, {8'd3, 8'd0}, {r(5), NR}, {32'hDEAD, 32'h0},
               {t(10), ND}, {32'h0, 32'hDEAD}, {ND, t(4)}, {32'hDEAD, 32'h0});
        // v4: x5 now committed, x7 and x9 still pending
        addVec(1, 0, 2'b00, {r(7), r(5)}, {r(1), r(9)}, {NR, NR}, 16'h0,
               2'b00, 16'h0, {NR, NR}, 64'h0,
               {t(4), ND}, {32'h0, 32'hDEAD}, {ND, t(10)}, 64'h0);
        // v5: commit RoB4 x7=1234 while slot1 renames x7->9
        addVec(1, 0, 2'b10, {r(7), r(7)}, {r(5), r(9)}, {r(7), NR}, {8'd9, 8'd0},
               2'b01, {8'd0, 8'd4}, {NR, r(7)}, {32'h0, 32'h1234},
               {ND, ND}, {32'h1234, 32'h1234}, {ND, t(10)}, {32'hDEAD, 32'h0});
        // v6: x7 stays renamed; two commits to x12 (slot1 wins); rename x1->4, x2->6
        addVec(1, 0, 2'b11, {r(3), r(7)}, {r(4), r(12)}, {r(2), r(1)}, {8'd6, 8'd4},
               2'b11, {8'd21, 8'd20}, {r(12), r(12)}, {32'h22, 32'h11},
               {ND, t(9)}, 64'h0, {ND, ND}, 64'h0);
        // v7: flush with commit RoB4 x1=7 and a discarded rename of x3
        addVec(1, 1, 2'b11, {r(3), r(1)}, {r(2), r(9)}, {NR, r(3)}, {8'd0, 8'd12},
               2'b01, {8'd0, 8'd4}, {NR, r(1)}, {32'h0, 32'h7},
               {ND, ND}, 64'h0, {ND, ND}, 64'h0);
        // v8: after flush every dep is clear; reg x1=7, x12=22
        addVec(1, 0, 2'b00, {r(2), r(1)}, {r(12), r(3)}, {NR, NR}, 16'h0,
               2'b00, 16'h0, {NR, NR}, 64'h0,
               {ND, ND}, {32'h0, 32'h7}, {ND, ND}, {32'h22, 32'h0});
        // v9: dispatch and commit to x0 are ignored; x7 dep cleared by the flush
        addVec(1, 0, 2'b11, {r(0), r(0)}, {r(7), r(7)}, {NR, r(0)}, {8'd5, 8'd1},
               2'b01, {8'd0, 8'd2}, {NR, r(0)}, {32'h0, 32'h55},
               {ND, ND}, 64'h0, {ND, ND}, {32'h1234, 32'h1234});
        // v10: both slots rename x20 (slot1 wins); slot1 sees slot0's tag
        addVec(1, 0, 2'b11, {r(20), r(0)}, {r(1), NR}, {r(20), r(20)}, {8'd31, 8'd30},
               2'b00, 16'h0, {NR, NR}, 64'h0,
               {t(30), ND}, 64'h0, {ND, ND}, {32'h7, 32'h0});
        // v11: Sys_rdy low, reads still combinational, no state update
        addVec(0, 0, 2'b01, {r(21), r(20)}, {r(0), r(7)}, {NR, r(21)}, {8'd0, 8'd40},
               2'b11, {8'd50, 8'd31}, {r(7), r(20)}, {32'hAAAA, 32'h99},
               {t(40), ND}, {32'h0, 32'h99}, {ND, ND}, {32'h0, 32'h1234});
        // v12: state unchanged by the frozen cycle
        addVec(1, 0, 2'b00, {r(21), r(20)}, {r(12), r(7)}, {NR, NR}, 16'h0,
               2'b00, 16'h0, {NR, NR}, 64'h0,
               {ND, t(31)}, 64'h0, {ND, ND}, {32'h22, 32'h1234});

        Sys_rst = 1'b1;
        applyStimulus(vecs[0]);
        #2;
        checkAll("in_reset", vecs[0]);
        @(posedge Sys_clk);
        @(posedge Sys_clk);
        #1;
        Sys_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkAll($sformatf("v%0d", i), vecs[i]);
            @(posedge Sys_clk);
            #1;
        end

        // Asynchronous reset asserted between clock edges must clear state at once.
        applyStimulus(vecs[12]);
        #2;
        checkOutput("pre_rst_qj", 64'(RFDP_Qj), 64'({ND, t(31)}));
        #1;
        Sys_rst = 1'b1;
        #1;
        checkOutput("mid_rst_qj", 64'(RFDP_Qj), 64'({ND, ND}));
        checkOutput("mid_rst_vk", RFDP_Vk, 64'h0);
        @(posedge Sys_clk);
        #1;
        Sys_rst = 1'b0;
        #2;
        checkOutput("post_rst_qj", 64'(RFDP_Qj), 64'({ND, ND}));
        checkOutput("post_rst_vk", RFDP_Vk, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised, multi-issue successor to the single-port architectural register file and dependency table.
- Holds 2^REG_WIDTH architectural values plus a per-register RoB dependency tag.
- Serves DP_WIDTH dispatch slots per cycle, each with two source reads, and accepts CM_WIDTH in-order commits per cycle.
- New behaviour: intra-group forwarding between dispatch slots, multi-commit bypass, x0 hardwired to zero, and a single-cycle mispredict flush.

Parameters:
- XLEN, 32, data width.
- REG_WIDTH, 5, architectural register index width. Extended index is REG_WIDTH+1 bits; MSB=1 means no register (NON_REG).
- ROB_WIDTH, 8, RoB index width. Extended tag is ROB_WIDTH+1 bits; MSB=1 means no dependency (NON_DEP).
- DP_WIDTH, 2, dispatch slots per cycle. Slot 0 is oldest.
- CM_WIDTH, 2, commit slots per cycle. Slot 0 is oldest.

Ports:
- Sys_clk  in  1  the single clock.
- Sys_rst  in  1  asynchronous, active-high reset.
- Sys_rdy  in  1  global enable. When low, state is frozen.
- DPRF_en  in  DP_WIDTH  per-slot dispatch valid.
- DPRF_rs1, DPRF_rs2  in  DP_WIDTH*(REG_WIDTH+1)  per-slot sources.
- DPRF_rd  in  DP_WIDTH*(REG_WIDTH+1)  per-slot destination.
- DPRF_RoB_index  in  DP_WIDTH*ROB_WIDTH  RoB entry allocated to each slot.
- RFDP_Qj, RFDP_Qk  out  DP_WIDTH*(ROB_WIDTH+1)  per-slot operand tags.
- RFDP_Vj, RFDP_Vk  out  DP_WIDTH*XLEN  per-slot operand values.
- RoBRF_en  in  CM_WIDTH  per-slot commit valid.
- RoBRF_RoB_index  in  CM_WIDTH*ROB_WIDTH  committing RoB entries.
- RoBRF_rd  in  CM_WIDTH*(REG_WIDTH+1)  commit destinations.
- RoBRF_value  in  CM_WIDTH*XLEN  commit results.
- RoBRF_flush  in  1  mispredict flush; active high.

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of Sys_rdy):
  - All registers are set to 0 and all dependency tags to NON_DEP.
  - Consequently every Q output reads NON_DEP and every V output reads 0 until the first dispatch.
- Read path: combinational, 0-cycle latency. For each source s of dispatch slot j, priority is highest first:
  1. s is NON_REG or x0: Q=NON_DEP, V=0.
  2. RoBRF_flush=1: Q=NON_DEP, V=0. Dispatch is discarded upstream.
  3. Intra-group forwarding: the highest-numbered slot i<j with DPRF_en[i]=1 and DPRF_rd[i]==s supplies Q={0,DPRF_RoB_index[i]}, V=0.
  4. Commit bypass: dep[s] matches a valid commit tag k with RoBRF_rd[k]==s: Q=NON_DEP, V=RoBRF_value[k]. If several commits match, the highest k wins.
  5. dep[s]==NON_DEP: Q=NON_DEP, V=reg[s].
  6. Otherwise: Q=dep[s], V=0.
- Update on posedge Sys_clk, only while Sys_rdy=1:
  - Commit writes:
    - Each valid commit whose rd is neither NON_REG nor x0 writes its value into reg[rd].
    - If several commit slots write the same rd, the highest slot wins.
  - Commit clear:
    - dep[rd] becomes NON_DEP when some valid commit k has rd==RoBRF_rd[k] and dep[rd]=={0,RoBRF_RoB_index[k]}.
    - This clear is suppressed if any valid dispatch this cycle writes the same rd.
  - Dispatch rename (only when RoBRF_flush=0):
    - Each valid slot whose rd is neither NON_REG nor x0 sets dep[rd]={0,DPRF_RoB_index}.
    - If several slots write the same rd, the highest slot wins.
    - Dispatch rename takes priority over commit clear.
  - Flush (RoBRF_flush=1):
    - Commit value writes still occur. The RoB presents only the mispredicting branch and older entries.
    - All dep entries become NON_DEP.
    - All dispatch slots are ignored.
- x0: reg[0] is never written and dep[0] is never set.
- Sys_rdy=0: no state change. Read outputs stay combinational on the current inputs.

Decomposition:
- Package rf_pkg holds:
  - width localparams;
  - NON_REG and NON_DEP constants;
  - functions is_reg(idx) and mk_tag(rob).
- One sub-module, rf_read_port, resolves a single source operand. It is instantiated 2*DP_WIDTH times, and each instance receives its slot number so it can apply the older-slot forwarding mask.
- The top level holds the storage arrays and the update logic.

Test Plan:
- Reset with Sys_rdy=1 and every rs1/rs2 in 1..31 -> all Q=NON_DEP, V=0. Assert Sys_rst mid-cycle -> state clears without waiting for a clock edge.
- Dispatch slot0 rd=x5 RoB=3 and slot1 rs1=x5 in the same cycle -> slot1 Qj=3, Vj=0. Next cycle a fresh read of x5 -> Qj=3.
- With dep[x5]=3, commit slot1 RoB=3 rd=x5 value=0xDEAD, alongside a same-cycle dispatch reading x5 -> Qj=NON_DEP, Vj=0xDEAD. Next cycle reg[x5]=0xDEAD and dep[x5]=NON_DEP.
- Commit RoB=3 rd=x5 while dispatch renames x5 to RoB=9 in the same cycle -> dep[x5]=9 afterwards and reg[x5] updated.
- With dep[x1]=4 and dep[x2]=6, assert flush with commit RoB=4 rd=x1 value=7, plus a dispatch renaming x3 -> all Q=NON_DEP that cycle. Afterwards reg[x1]=7, all dep=NON_DEP, and x3 is not renamed.
- Dispatch rd=x0 and commit rd=x0 value=0x55 -> reg[0]=0 and reading x0 gives Q=NON_DEP, V=0. With Sys_rdy=0, a commit to x7 -> reg[x7] unchanged.
